// File: rtl/corelet_ctrl_pkg.sv
// Shared types and constants for the corelet controller: FSM states,
// in_ctrl bit positions and the inst_w encodings.
package corelet_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_L0,
      S_W_ARR,
      S_A_L0,
      S_EXEC,
      S_DRAIN,
      S_OF_RD,
      S_ACC,
      S_DONE
   } state_t;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned CTRL_W = 12;
   localparam int unsigned C_W    = 9;

   // in_ctrl bit positions
   localparam int unsigned B_L0_WR     = 2;
   localparam int unsigned B_L0_RD     = 3;
   localparam int unsigned B_OFIFO_RD  = 6;
   localparam int unsigned B_SFP_ACC   = 7;
   localparam int unsigned B_SFP_RELU  = 8;
   localparam int unsigned B_SFP_RESET = 10;
   localparam int unsigned B_SFP_SEL   = 11;

   // inst_w field, in_ctrl[1:0]
   localparam logic [1:0] INST_NONE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/corelet_ctrl_agu.sv
// Address generator: owns the kij (k), vector (t) and step (c) counters
// and derives every memory address from them with 11-bit wrapping math.
module corelet_ctrl_agu
   import corelet_ctrl_pkg::*;
#(
   parameter int unsigned col    = 8,
   parameter int unsigned w_base = 1024,
   parameter int unsigned o_base = 1536
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        i_len,
   input  logic              i_k_clr,
   input  logic              i_k_inc,
   input  logic              i_t_clr,
   input  logic              i_t_inc,
   input  logic              i_c_clr,
   input  logic              i_c_inc,
   output logic [3:0]        o_k,
   output logic [7:0]        o_t,
   output logic [C_W-1:0]    o_c,
   output logic [ADDR_W-1:0] o_xw_addr,
   output logic [ADDR_W-1:0] o_xa_addr,
   output logic [ADDR_W-1:0] o_of_addr,
   output logic [ADDR_W-1:0] o_acc_addr,
   output logic [ADDR_W-1:0] o_out_addr
);

   logic [3:0]     r_k;
   logic [7:0]     r_t;
   logic [C_W-1:0] r_c;

   // Counter updates; a clear always wins over an increment
   always_ff @(posedge clk) begin
      if (reset) begin
         r_k <= '0;
         r_t <= '0;
         r_c <= '0;
      end else begin
         if (i_k_clr)      r_k <= '0;
         else if (i_k_inc) r_k <= r_k + 4'd1;
         if (i_t_clr)      r_t <= '0;
         else if (i_t_inc) r_t <= r_t + 8'd1;
         if (i_c_clr)      r_c <= '0;
         else if (i_c_inc) r_c <= r_c + 9'd1;
      end
   end

   // Address arithmetic; ACC uses c-1 as the kij index of the psum read
   always_comb begin
      o_xw_addr  = ADDR_W'(w_base) + ADDR_W'(r_k) * ADDR_W'(col) + ADDR_W'(r_c);
      o_xa_addr  = ADDR_W'(r_k) * ADDR_W'(i_len) + ADDR_W'(r_c);
      o_of_addr  = ADDR_W'(r_k) * ADDR_W'(i_len) + ADDR_W'(r_t);
      o_acc_addr = (ADDR_W'(r_c) - ADDR_W'(1)) * ADDR_W'(i_len) + ADDR_W'(r_t);
      o_out_addr = ADDR_W'(o_base) + ADDR_W'(r_t);
   end

   assign o_k = r_k;
   assign o_t = r_t;
   assign o_c = r_c;

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet job sequencer: per kij loads weights and activations into L0,
// executes, drains, copies ofifo results to pmem, then accumulates all
// kij partial sums per vector into the final output region. Every output
// is a register; delayed strobes (l0_wr, psum sfp_acc) are derived from
// the registered read strobes so they land exactly one cycle later.
module corelet_ctrl
   import corelet_ctrl_pkg::*;
#(
   parameter int unsigned row       = 8,
   parameter int unsigned col       = 8,
   parameter int unsigned drain_cyc = 16,
   parameter int unsigned w_base    = 1024,
   parameter int unsigned o_base    = 1536
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        len,
   input  logic [3:0]        n_kij,
   input  logic              relu_en,
   output logic              busy,
   output logic              done,
   output logic [CTRL_W-1:0] in_ctrl,
   output logic              xmem_cen,
   output logic [ADDR_W-1:0] xmem_addr,
   output logic              pmem_cen,
   output logic              pmem_wen,
   output logic [ADDR_W-1:0] pmem_addr
);

   if (row < 1 || col < 1 || drain_cyc < 1) begin : g_bad_param
      $error("corelet_ctrl: row, col and drain_cyc must be at least 1");
   end

   state_t              r_state, w_nxt;
   logic [7:0]          r_len;
   logic [3:0]          r_nkij;
   logic                r_relu;
   logic                r_busy, r_done, r_xcen, r_pcen, r_pwen;
   logic [CTRL_W-1:0]   r_ctrl, w_ctrl;
   logic [ADDR_W-1:0]   r_xaddr, r_paddr, w_xaddr, w_paddr;
   logic                w_xcen, w_pcen, w_pwen;
   logic                w_k_clr, w_k_inc, w_t_clr, w_t_inc, w_c_clr, w_c_inc;
   logic [3:0]          w_k;
   logic [7:0]          w_t;
   logic [C_W-1:0]      w_c, w_wr_p;
   logic [ADDR_W-1:0]   w_xw_addr, w_xa_addr, w_of_addr, w_acc_addr, w_out_addr;

   corelet_ctrl_agu #(
      .col    (col),
      .w_base (w_base),
      .o_base (o_base)
   ) u_agu (
      .clk        (clk),
      .reset      (reset),
      .i_len      (r_len),
      .i_k_clr    (w_k_clr),
      .i_k_inc    (w_k_inc),
      .i_t_clr    (w_t_clr),
      .i_t_inc    (w_t_inc),
      .i_c_clr    (w_c_clr),
      .i_c_inc    (w_c_inc),
      .o_k        (w_k),
      .o_t        (w_t),
      .o_c        (w_c),
      .o_xw_addr  (w_xw_addr),
      .o_xa_addr  (w_xa_addr),
      .o_of_addr  (w_of_addr),
      .o_acc_addr (w_acc_addr),
      .o_out_addr (w_out_addr)
   );

   // ACC step holding the final write: reset, n_kij reads, last-acc slot, optional relu
   assign w_wr_p = C_W'(r_nkij) + C_W'(2) + C_W'(r_relu);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   // Job parameters captured when a job is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len  <= '0;
         r_nkij <= '0;
         r_relu <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_len  <= len;
         r_nkij <= n_kij;
         r_relu <= relu_en;
      end
   end

   // Next state, counter commands and next values of every output
   always_comb begin
      w_nxt   = r_state;
      w_ctrl  = '0;
      w_xcen  = 1'b1;
      w_xaddr = '0;
      w_pcen  = 1'b1;
      w_pwen  = 1'b1;
      w_paddr = '0;
      w_k_clr = 1'b0;
      w_k_inc = 1'b0;
      w_t_clr = 1'b0;
      w_t_inc = 1'b0;
      w_c_clr = 1'b0;
      w_c_inc = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_k_clr = 1'b1;
            w_t_clr = 1'b1;
            w_c_clr = 1'b1;
            if (start) w_nxt = (len != 8'd0 && n_kij != 4'd0) ? S_W_L0 : S_DONE;
         end
         // col weight reads plus one slot for the trailing l0_wr
         S_W_L0: begin
            if (w_c < C_W'(col)) begin
               w_xcen  = 1'b0;
               w_xaddr = w_xw_addr;
            end
            if (w_c == C_W'(col)) begin
               w_c_clr = 1'b1;
               w_nxt   = S_W_ARR;
            end else w_c_inc = 1'b1;
         end
         S_W_ARR: begin
            w_ctrl[B_L0_RD] = 1'b1;
            w_ctrl[1:0]     = INST_KLOAD;
            if (w_c == C_W'(col - 1)) begin
               w_c_clr = 1'b1;
               w_nxt   = S_A_L0;
            end else w_c_inc = 1'b1;
         end
         S_A_L0: begin
            if (w_c < C_W'(r_len)) begin
               w_xcen  = 1'b0;
               w_xaddr = w_xa_addr;
            end
            if (w_c == C_W'(r_len)) begin
               w_c_clr = 1'b1;
               w_nxt   = S_EXEC;
            end else w_c_inc = 1'b1;
         end
         S_EXEC: begin
            w_ctrl[B_L0_RD] = 1'b1;
            w_ctrl[1:0]     = INST_EXEC;
            if (w_c == C_W'(r_len) - C_W'(1)) begin
               w_c_clr = 1'b1;
               w_nxt   = S_DRAIN;
            end else w_c_inc = 1'b1;
         end
         S_DRAIN: begin
            if (w_c == C_W'(drain_cyc - 1)) begin
               w_c_clr = 1'b1;
               w_t_clr = 1'b1;
               w_nxt   = S_OF_RD;
            end else w_c_inc = 1'b1;
         end
         S_OF_RD: begin
            case (w_c)
               C_W'(0): begin
                  w_ctrl[B_SFP_RESET] = 1'b1;
                  w_c_inc             = 1'b1;
               end
               C_W'(1): begin
                  w_ctrl[B_OFIFO_RD] = 1'b1;
                  w_ctrl[B_SFP_ACC]  = 1'b1;
                  w_c_inc            = 1'b1;
               end
               default: begin
                  w_pcen  = 1'b0;
                  w_pwen  = 1'b0;
                  w_paddr = w_of_addr;
                  w_c_clr = 1'b1;
                  if (w_t == r_len - 8'd1) begin
                     w_t_clr = 1'b1;
                     if (w_k == r_nkij - 4'd1) w_nxt = S_ACC;
                     else begin
                        w_k_inc = 1'b1;
                        w_nxt   = S_W_L0;
                     end
                  end else w_t_inc = 1'b1;
               end
            endcase
         end
         S_ACC: begin
            w_ctrl[B_SFP_SEL] = 1'b1;
            if (w_c == C_W'(0)) begin
               w_ctrl[B_SFP_RESET] = 1'b1;
               w_c_inc             = 1'b1;
            end else if (w_c <= C_W'(r_nkij)) begin
               w_pcen  = 1'b0;
               w_paddr = w_acc_addr;
               w_c_inc = 1'b1;
            end else if (w_c == w_wr_p) begin
               w_pcen  = 1'b0;
               w_pwen  = 1'b0;
               w_paddr = w_out_addr;
               w_c_clr = 1'b1;
               if (w_t == r_len - 8'd1) w_nxt = S_DONE;
               else                     w_t_inc = 1'b1;
            end else begin
               if (r_relu && w_c == C_W'(r_nkij) + C_W'(2)) w_ctrl[B_SFP_RELU] = 1'b1;
               w_c_inc = 1'b1;
            end
         end
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      // Data from a read strobe issued last cycle is consumed this cycle
      w_ctrl[B_L0_WR] = ~r_xcen;
      if (~r_pcen & r_pwen) w_ctrl[B_SFP_ACC] = 1'b1;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ctrl  <= '0;
         r_xcen  <= 1'b1;
         r_xaddr <= '0;
         r_pcen  <= 1'b1;
         r_pwen  <= 1'b1;
         r_paddr <= '0;
      end else begin
         r_busy  <= (w_nxt != S_IDLE);
         r_done  <= (w_nxt == S_DONE);
         r_ctrl  <= w_ctrl;
         r_xcen  <= w_xcen;
         r_xaddr <= w_xaddr;
         r_pcen  <= w_pcen;
         r_pwen  <= w_pwen;
         r_paddr <= w_paddr;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign in_ctrl   = r_ctrl;
   assign xmem_cen  = r_xcen;
   assign xmem_addr = r_xaddr;
   assign pmem_cen  = r_pcen;
   assign pmem_wen  = r_pwen;
   assign pmem_addr = r_paddr;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: a negedge monitor records memory traffic and
// rule violations; each job's recorded traffic is compared with address
// lists built from the job's loop structure (kij, vector, column).
module tb_corelet_ctrl;

   localparam int COL   = 8;
   localparam int DRAIN = 16;
   localparam int WB    = 1024;
   localparam int OB    = 1536;

   logic        clk = 1'b0;
   logic        reset, start, relu_en;
   logic [7:0]  len;
   logic [3:0]  n_kij;
   logic        busy, done, xmem_cen, pmem_cen, pmem_wen;
   logic [11:0] in_ctrl;
   logic [10:0] xmem_addr, pmem_addr;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   corelet_ctrl #(
      .row(8), .col(COL), .drain_cyc(DRAIN), .w_base(WB), .o_base(OB)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .n_kij(n_kij),
      .relu_en(relu_en), .busy(busy), .done(done), .in_ctrl(in_ctrl),
      .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .pmem_cen(pmem_cen),
      .pmem_wen(pmem_wen), .pmem_addr(pmem_addr)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   int xq[$], pwq[$], prq[$];
   int n_done = 0, n_relu = 0, n_acc0 = 0, n_acc1 = 0, n_l0rd = 0, n_kload = 0, n_exec = 0;
   int v_l0wr = 0, v_psacc = 0, v_rsvd = 0, v_inst = 0, v_idle = 0, v_ofacc = 0;
   int v_drain = 0, v_order = 0;
   int accs_since = 0, relu_since = 0, last_exec = 0, cyc = 0;
   bit exec_pend = 0, prev_xrd = 0, prev_prd = 0, prev_rst = 1;
   int job_n = 1, job_relu = 0;

   // Per-cycle observation of all DUT outputs
   always @(negedge clk) begin : mon
      bit xrd, prd, pwr, psacc;
      cyc++;
      xrd   = !xmem_cen;
      prd   = !pmem_cen && pmem_wen;
      pwr   = !pmem_cen && !pmem_wen;
      psacc = in_ctrl[7] && in_ctrl[11];
      if (!prev_rst) begin
         if (in_ctrl[2] != prev_xrd) v_l0wr++;
         if (psacc != prev_prd) v_psacc++;
      end
      if (in_ctrl[5:4] != 2'b00 || in_ctrl[9]) v_rsvd++;
      if (in_ctrl[1:0] == 2'b11) v_inst++;
      if (!busy && {in_ctrl, xmem_cen, pmem_cen, pmem_wen} != {12'h000, 3'b111}) v_idle++;
      if (in_ctrl[7] && !in_ctrl[11]) begin
         n_acc0++;
         if (!in_ctrl[6]) v_ofacc++;
      end
      if (done) n_done++;
      if (in_ctrl[3]) n_l0rd++;
      if (in_ctrl[1:0] == 2'b01) n_kload++;
      if (in_ctrl[1:0] == 2'b10) begin
         n_exec++;
         last_exec = cyc;
         exec_pend = 1;
      end
      if (in_ctrl[10] && !in_ctrl[11] && exec_pend) begin
         if (cyc - last_exec - 1 != DRAIN) v_drain++;
         exec_pend = 0;
      end
      if (in_ctrl[10] && in_ctrl[11]) begin
         accs_since = 0;
         relu_since = 0;
      end
      if (psacc) begin
         n_acc1++;
         accs_since++;
      end
      if (in_ctrl[8]) begin
         n_relu++;
         relu_since++;
         if (accs_since != job_n) v_order++;
      end
      if (xrd) xq.push_back(int'(xmem_addr));
      if (prd) prq.push_back(int'(pmem_addr));
      if (pwr) begin
         pwq.push_back(int'(pmem_addr));
         if (in_ctrl[11] && (accs_since != job_n || relu_since != job_relu)) v_order++;
      end
      prev_xrd = xrd;
      prev_prd = prd;
      prev_rst = reset;
   end

   function automatic int viol_sum();
      return v_l0wr + v_psacc + v_rsvd + v_inst + v_idle + v_ofacc + v_drain + v_order;
   endfunction

   task automatic cmp_q(input string tag, input int q[$], input int base, input int exp[$]);
      int f0;
      int n;
      f0 = n_fail;
      check_val({tag, "_count"}, q.size() - base, exp.size());
      n = (q.size() - base < exp.size()) ? q.size() - base : exp.size();
      for (int i = 0; i < n; i++) begin
         check_val(tag, q[base + i], exp[i]);
         if (n_fail != f0) break;
      end
   endtask

   // Run one job from start to done and compare its traffic with the model
   task automatic run_job(input int L, input int N, input int R, input bit pulse, output int dur);
      int bx, bpw, bpr, bd, brl, ba0, ba1, brd, bkl, bex, bv;
      int ex[$];
      bit got;
      bx = xq.size(); bpw = pwq.size(); bpr = prq.size();
      bd = n_done; brl = n_relu; ba0 = n_acc0; ba1 = n_acc1;
      brd = n_l0rd; bkl = n_kload; bex = n_exec; bv = viol_sum();
      job_n = N; job_relu = R;
      len = 8'(L); n_kij = 4'(N); relu_en = R[0]; start = 1'b1;
      tick();
      check_val("busy_go", busy, 1);
      got = 0;
      dur = 0;
      for (int i = 1; i <= 30000 && !got; i++) begin
         start = pulse && (i == 3 || i == 40);
         len   = start ? 8'd0 : 8'(L);
         tick();
         if (done) begin
            got = 1;
            dur = i;
         end
      end
      start = 1'b0;
      len   = 8'(L);
      check_val("done_seen", got, 1);
      repeat (4) tick();
      check_val("idle_after", busy, 0);
      check_val("done_pulses", n_done - bd, 1);
      ex = {};
      for (int k = 0; k < N; k++) begin
         for (int c = 0; c < COL; c++) ex.push_back((WB + k * COL + c) % 2048);
         for (int t = 0; t < L; t++)   ex.push_back((k * L + t) % 2048);
      end
      cmp_q("xmem_rd", xq, bx, ex);
      ex = {};
      for (int k = 0; k < N; k++)
         for (int t = 0; t < L; t++) ex.push_back((k * L + t) % 2048);
      for (int t = 0; t < L; t++) ex.push_back((OB + t) % 2048);
      cmp_q("pmem_wr", pwq, bpw, ex);
      ex = {};
      for (int t = 0; t < L; t++)
         for (int k = 0; k < N; k++) ex.push_back((k * L + t) % 2048);
      cmp_q("pmem_rd", prq, bpr, ex);
      check_val("relu_pulses", n_relu - brl, R * L);
      check_val("ofifo_acc", n_acc0 - ba0, N * L);
      check_val("psum_acc", n_acc1 - ba1, N * L);
      check_val("l0_rd", n_l0rd - brd, N * (COL + L));
      check_val("kload", n_kload - bkl, N * COL);
      check_val("exec", n_exec - bex, N * L);
      check_val("rule_viol", viol_sum() - bv, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_ctrl"}, in_ctrl, 0);
      check_val({tag, "_xcen"}, xmem_cen, 1);
      check_val({tag, "_pcen"}, pmem_cen, 1);
      check_val({tag, "_pwen"}, pmem_wen, 1);
      check_val({tag, "_xaddr"}, xmem_addr, 0);
      check_val({tag, "_paddr"}, pmem_addr, 0);
   endtask

   // Empty jobs: done on the next cycle with no memory strobes
   task automatic zero_job(input int L, input int N);
      int bx, bpw, bpr;
      bx = xq.size(); bpw = pwq.size(); bpr = prq.size();
      len = 8'(L); n_kij = 4'(N); start = 1'b1;
      tick();
      start = 1'b0;
      check_val("zero_done", done, 1);
      check_val("zero_xcen", xmem_cen, 1);
      tick();
      check_val("zero_done_off", done, 0);
      check_val("zero_busy_off", busy, 0);
      repeat (3) tick();
      check_val("zero_traffic", (xq.size() - bx) + (pwq.size() - bpw) + (prq.size() - bpr), 0);
   endtask

   initial begin
      int d0, d1, bex, bd;
      reset = 1'b1; start = 1'b0; len = 8'd0; n_kij = 4'd0; relu_en = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      run_job(4, 1, 0, 0, d0);
      run_job(2, 3, 0, 0, d0);
      run_job(1, 1, 1, 0, d0);

      zero_job(0, 3);
      zero_job(4, 0);

      // reset five cycles into EXEC, then a fresh complete job
      bex = n_exec; bd = n_done; job_n = 2; job_relu = 0;
      len = 8'd12; n_kij = 4'd2; relu_en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2000 && (n_exec - bex) < 5; i++) tick();
      check_val("exec_reached", (n_exec - bex) >= 5, 1);
      reset = 1'b1;
      tick();
      check_reset_outputs("midrst");
      reset = 1'b0;
      repeat (5) tick();
      check_val("midrst_no_done", n_done - bd, 0);
      check_val("midrst_idle", busy, 0);
      run_job(12, 2, 0, 0, d0);

      // start pulses while busy must not change the job
      run_job(5, 2, 1, 0, d0);
      run_job(5, 2, 1, 1, d1);
      check_val("busy_start_timing", d1, d0);

      run_job(255, 1, 1, 0, d0);
      run_job(3, 9, 1, 0, d0);
      repeat (6) run_job($urandom_range(1, 20), $urandom_range(1, 9), $urandom_range(0, 1), 0, d0);

      check_val("rule_viol_total", viol_sum(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
